i2cs_fifo_rd_stream: RTL and testbench
======================================

// Module: i2cs_fifo_rd_stream
// PURPOSE
//  Read-side drain engine for the 256x8 sync FIFOs in apb_i2cs.
//  - Pops bytes from a FIFO (pop/empty/rd_data interface) and presents them on a valid/ready byte stream.
//  - Stream consumer: I2C TX shifter or APB read mux.
//  - Hides FIFO read latency with a small skid buffer.
//  - No combinational path from m_ready_i to fifo_pop_o.
// PARAMETERS
//  RD_LATENCY  1  cycles from fifo_pop_o high to valid fifo_rd_data_i: 0 = same cycle, 1 = next cycle
//  SKID_DEPTH  3  output buffer entries; must be >= RD_LATENCY+2
// PORTS
//  clk_i           input   1  single clock, rising edge
//  rst_i           input   1  asynchronous reset, active-high
//  en_i            input   1  1 = drain allowed; 0 = no new pops (buffered data still drains)
//  flush_i         input   1  discard buffer contents and in-flight data (FIFO itself untouched)
//  fifo_empty_i    input   1  FIFO empty flag (registered, exact per cycle)
//  fifo_rd_data_i  input   8  FIFO head/read data
//  fifo_pop_o      output  1  FIFO pop strobe
//  m_valid_o       output  1  stream byte valid
//  m_data_o        output  8  stream byte
//  m_ready_i       input   1  stream consumer ready
//  buf_cnt_o       output  2  bytes currently held in skid buffer, 0..SKID_DEPTH
//  pop_cnt_o       output  16 total bytes popped (only with I2CS_RD_STATS_EN)
// BEHAVIOUR
//  Reset values (async on rst_i): fifo_pop_o=0, m_valid_o=0, m_data_o=8'h00, buf_cnt_o=0, pop_cnt_o=0.
//  Internal state also resets: inflight=0, wr/rd pointers=0.
//  Pop rule (combinational from registers and FIFO flags only):
//    fifo_pop_o = en_i & !flush_i & !fifo_empty_i & (buf_cnt + inflight < SKID_DEPTH)
//  inflight:
//    - RD_LATENCY=0: always 0.
//    - RD_LATENCY=1: 1-bit register = fifo_pop_o of the previous cycle.
//  Capture into buffer tail:
//    - RD_LATENCY=0: in the same cycle as fifo_pop_o.
//    - RD_LATENCY=1: in the cycle after fifo_pop_o, when inflight=1 and no flush in that cycle.
//  Output:
//    - m_valid_o = (buf_cnt != 0); m_data_o = buffer head.
//    - Handshake fires when m_valid_o & m_ready_i; head advances, buf_cnt decrements.
//    - Capture and handshake in the same cycle: buf_cnt unchanged, ordering preserved.
//  Stream rules:
//    - Once m_valid_o is high, it and m_data_o are held stable until the handshake or flush_i.
//    - m_valid_o never depends on m_ready_i.
//  Throughput: with FIFO non-empty and m_ready_i=1, one byte per cycle sustained for both latencies.
//  First-byte latency from fifo_empty_i falling: 1 cycle + RD_LATENCY.
//  Pointers: modulo SKID_DEPTH; wrap explicitly (non-power-of-2 depth); buf_cnt saturates at SKID_DEPTH by construction.
//  FIFO empty: no pop issued. A pop already issued at count 1 is valid; next cycle empty=1 blocks further pops.
//  flush_i (1 cycle or held):
//    - Next edge: buf_cnt=0, pointers=0, m_valid_o=0, inflight data dropped.
//    - No pop while flush_i=1.
//    - Bytes already removed from the FIFO are lost (intended: abort of I2C read).
//  en_i falling: pops stop immediately; the in-flight byte is still captured; buffer keeps draining.
//  Reset mid-transfer: all state cleared asynchronously; FIFO is reset by the same rst_i.
// CONFIGURATION
//  I2CS_RD_STATS_EN defined:
//    - pop_cnt_o increments by 1 on every cycle with fifo_pop_o=1.
//    - Wraps 16'hFFFF -> 0; cleared only by rst_i (not by flush_i).
//  I2CS_RD_STATS_EN undefined: counter register removed; pop_cnt_o tied to 16'h0000.
// TESTING
//  1. FIFO holds 0x11,0x22,0x33; en=1, ready=1, RD_LATENCY=1 -> stream 0x11,0x22,0x33 on consecutive cycles; pop count 3; valid drops after last byte.
//  2. FIFO holds 10 bytes, ready=0 -> exactly SKID_DEPTH=3 pops, buf_cnt_o=3, m_data_o=first byte held stable; ready=1 -> remaining 10 bytes in order, 1/cycle.
//  3. FIFO holds 1 byte, en=1 -> single pop; no second pop while empty=1; one byte out; buf_cnt_o returns to 0.
//  4. flush_i asserted with buf_cnt=2 and inflight=1 -> next cycle m_valid_o=0, buf_cnt_o=0; in-flight byte never appears; draining resumes with the next FIFO byte after flush_i drops.
//  5. ready toggled randomly 1000 cycles, 300 bytes, both RD_LATENCY values -> output equals input order, no drop or duplicate; valid/data stable while stalled.
//  6. I2CS_RD_STATS_EN on: 70000 pops -> pop_cnt_o = 70000 mod 65536 = 4464. Macro off: pop_cnt_o = 0 throughout.

Source files
------------

// File: rtl/i2cs_fifo_rd_stream.sv
// FIFO read-side drain engine: pops a 256x8 sync FIFO into a skid buffer and presents a valid/ready byte stream.
// Optional pop statistics counter enabled by defining I2CS_RD_STATS_EN.
module i2cs_fifo_rd_stream #(
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned SKID_DEPTH = 3,
    localparam int unsigned CNT_W = $clog2(SKID_DEPTH + 1),
    localparam int unsigned PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             flush_i,
    input  logic             fifo_empty_i,
    input  logic [7:0]       fifo_rd_data_i,
    output logic             fifo_pop_o,
    output logic             m_valid_o,
    output logic [7:0]       m_data_o,
    input  logic             m_ready_i,
    output logic [CNT_W-1:0] buf_cnt_o,
    output logic [15:0]      pop_cnt_o
);

    localparam int unsigned OCC_W = CNT_W + 1;

    logic [7:0]       mem_q [SKID_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inflight;
    logic             pop;
    logic             cap;
    logic             hs;
    logic [OCC_W-1:0] occ;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Occupancy counts the byte still on its way from the FIFO so the buffer never overflows.
    assign occ = OCC_W'(cnt_q) + OCC_W'(inflight);
    assign pop = en_i & ~flush_i & ~fifo_empty_i & (occ < OCC_W'(SKID_DEPTH));
    assign hs  = (cnt_q != '0) & m_ready_i;

    generate
        if (RD_LATENCY == 0) begin : g_lat0
            assign inflight = 1'b0;
            assign cap      = pop;
        end else begin : g_lat1
            logic inflight_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    inflight_q <= 1'b0;
                end else begin
                    inflight_q <= pop;
                end
            end

            assign inflight = inflight_q;
            assign cap      = inflight_q & ~flush_i;
        end
    endgenerate

    // Pointer/count next state; flush wins over capture and handshake.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (cap) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (hs) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({cap, hs})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(SKID_DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (cap) begin
            mem_q[wr_ptr_q] <= fifo_rd_data_i;
        end
    end

    assign fifo_pop_o = pop;
    assign m_valid_o  = (cnt_q != '0);
    assign m_data_o   = mem_q[rd_ptr_q];
    assign buf_cnt_o  = cnt_q;

`ifdef I2CS_RD_STATS_EN
    logic [15:0] pop_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pop_cnt_q <= 16'h0000;
        end else if (pop) begin
            pop_cnt_q <= pop_cnt_q + 16'd1;
        end
    end

    assign pop_cnt_o = pop_cnt_q;
`else
    assign pop_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_i2cs_fifo_rd_stream.sv
// Bench for i2cs_fifo_rd_stream: RD_LATENCY=1 and RD_LATENCY=0 instances side by side with FIFO models.
module tb_i2cs_fifo_rd_stream;

    logic        clk, rst, en, flush, ready;
    logic        e1, e0;
    logic [7:0]  rd1, rd0;
    logic        pop1, pop0, v1, v0;
    logic [7:0]  d1, d0;
    logic [1:0]  c1, c0;
    logic [15:0] pc1, pc0;

    i2cs_fifo_rd_stream #(.RD_LATENCY(1), .SKID_DEPTH(3)) dut1 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(flush),
        .fifo_empty_i(e1), .fifo_rd_data_i(rd1), .fifo_pop_o(pop1),
        .m_valid_o(v1), .m_data_o(d1), .m_ready_i(ready),
        .buf_cnt_o(c1), .pop_cnt_o(pc1)
    );

    i2cs_fifo_rd_stream #(.RD_LATENCY(0), .SKID_DEPTH(3)) dut0 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(flush),
        .fifo_empty_i(e0), .fifo_rd_data_i(rd0), .fifo_pop_o(pop0),
        .m_valid_o(v0), .m_data_o(d0), .m_ready_i(ready),
        .buf_cnt_o(c0), .pop_cnt_o(pc0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       en;
        logic       ready;
        logic       flush;
        logic       pop;
        logic       valid;
        logic [7:0] data;
        logic [1:0] cnt;
    } vec_t;

    vec_t vecs[6];

    logic [7:0] q1[$], q0[$], exp1[$], exp0[$];
    int n_chk, n_err;
    int npop1, npop0, dl1, dl0;
    logic p1, p0, hold1, hold0;
    logic [7:0] hd1, hd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic refresh();
        e1  = (q1.size() == 0);
        e0  = (q0.size() == 0);
        rd0 = (q0.size() != 0) ? q0[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        q1.push_back(b);
        q0.push_back(b);
        refresh();
    endtask

    // Called at the negative edge: scoreboard, stall stability and pop statistics.
    task automatic observe();
        if (hold1) begin
            chk("stable_valid1", 32'(v1), 32'd1);
            chk("stable_data1", 32'(d1), 32'(hd1));
        end
        if (hold0) begin
            chk("stable_valid0", 32'(v0), 32'd1);
            chk("stable_data0", 32'(d0), 32'(hd0));
        end
        if (v1 && ready) begin
            if (exp1.size() == 0) chk("spurious_byte1", 32'd1, 32'd0);
            else chk("stream_data1", 32'(d1), 32'(exp1.pop_front()));
            dl1++;
        end
        if (v0 && ready) begin
            if (exp0.size() == 0) chk("spurious_byte0", 32'd1, 32'd0);
            else chk("stream_data0", 32'(d0), 32'(exp0.pop_front()));
            dl0++;
        end
`ifdef I2CS_RD_STATS_EN
        chk("pop_cnt1", 32'(pc1), 32'(npop1[15:0]));
        chk("pop_cnt0", 32'(pc0), 32'(npop0[15:0]));
`else
        chk("pop_cnt1", 32'(pc1), 32'd0);
        chk("pop_cnt0", 32'(pc0), 32'd0);
`endif
        if (flush) begin
            exp1.delete();
            exp0.delete();
        end
        hold1 = v1 & ~ready & ~flush;
        hold0 = v0 & ~ready & ~flush;
        hd1 = d1;
        hd0 = d0;
        p1 = pop1;
        p0 = pop0;
        if (p1) npop1++;
        if (p0) npop0++;
    endtask

    // FIFO model update just after the active edge.
    task automatic advance();
        logic [7:0] b;
        @(posedge clk);
        #1;
        if (p1) begin
            b = q1.pop_front();
            rd1 = b;
            exp1.push_back(b);
        end
        if (p0) begin
            b = q0.pop_front();
            exp0.push_back(b);
        end
        refresh();
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        advance();
    endtask

    initial begin
        int base1, base0, bd1, bd0, guard;
        n_chk = 0; n_err = 0; npop1 = 0; npop0 = 0; dl1 = 0; dl0 = 0;
        hold1 = 0; hold0 = 0; hd1 = 0; hd0 = 0; p1 = 0; p0 = 0;
        rst = 1'b1; en = 1'b0; flush = 1'b0; ready = 1'b0; rd1 = 8'h00;
        refresh();

        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 2'd1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 2'd1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 2'd1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_pop", 32'(pop1), 32'd0);
        chk("rst_valid", 32'(v1), 32'd0);
        chk("rst_data", 32'(d1), 32'h00);
        chk("rst_cnt", 32'(c1), 32'd0);
        chk("rst_popcnt", 32'(pc1), 32'd0);
        chk("rst_valid0", 32'(v0), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Three bytes at full rate, table driven
        push(8'h11); push(8'h22); push(8'h33);
        base1 = npop1;
        for (int i = 0; i < 6; i++) begin
            en = vecs[i].en; ready = vecs[i].ready; flush = vecs[i].flush;
            @(negedge clk);
            chk($sformatf("vec%0d_pop", i), 32'(pop1), 32'(vecs[i].pop));
            chk($sformatf("vec%0d_valid", i), 32'(v1), 32'(vecs[i].valid));
            chk($sformatf("vec%0d_cnt", i), 32'(c1), 32'(vecs[i].cnt));
            if (vecs[i].valid) chk($sformatf("vec%0d_data", i), 32'(d1), 32'(vecs[i].data));
            observe();
            advance();
        end
        chk("t1_pops", 32'(npop1 - base1), 32'd3);

        // Stalled consumer fills the skid buffer and stops popping
        ready = 1'b0;
        for (int i = 0; i < 10; i++) push(8'hA0 + 8'(i));
        base1 = npop1; base0 = npop0;
        repeat (8) tick();
        chk("t2_pops1", 32'(npop1 - base1), 32'd3);
        chk("t2_pops0", 32'(npop0 - base0), 32'd3);
        chk("t2_cnt1", 32'(c1), 32'd3);
        chk("t2_cnt0", 32'(c0), 32'd3);
        chk("t2_head1", 32'(d1), 32'hA0);
        ready = 1'b1;
        bd1 = dl1; bd0 = dl0;
        repeat (10) tick();
        chk("t2_drain1", 32'(dl1 - bd1), 32'd10);
        chk("t2_drain0", 32'(dl0 - bd0), 32'd10);
        chk("t2_idle1", 32'(v1), 32'd0);

        // Single byte: one pop only
        push(8'hC5);
        base1 = npop1; bd1 = dl1;
        repeat (6) tick();
        chk("t3_pops", 32'(npop1 - base1), 32'd1);
        chk("t3_out", 32'(dl1 - bd1), 32'd1);
        chk("t3_cnt", 32'(c1), 32'd0);

        // Flush with two buffered bytes and one in flight
        ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'hB0 + 8'(i));
        repeat (3) tick();
        chk("t4_cnt_pre", 32'(c1), 32'd2);
        flush = 1'b1;
        @(negedge clk);
        chk("t4_no_pop", 32'(pop1), 32'd0);
        observe();
        advance();
        flush = 1'b0;
        chk("t4_valid", 32'(v1), 32'd0);
        chk("t4_cnt", 32'(c1), 32'd0);
        ready = 1'b1;
        bd1 = dl1; bd0 = dl0;
        repeat (12) tick();
        chk("t4_after1", 32'(dl1 - bd1), 32'd2);
        chk("t4_after0", 32'(dl0 - bd0), 32'd2);

        // Random ready/enable stress, 300 bytes
        for (int i = 0; i < 300; i++) push(8'($urandom_range(0, 255)));
        bd1 = dl1; bd0 = dl0;
        for (int i = 0; i < 1000; i++) begin
            ready = 1'($urandom_range(0, 1));
            en    = ($urandom_range(0, 9) != 0);
            tick();
        end
        ready = 1'b1; en = 1'b1;
        guard = 0;
        while (((dl1 - bd1) < 300 || (dl0 - bd0) < 300) && guard < 400) begin
            tick();
            guard++;
        end
        chk("t5_count1", 32'(dl1 - bd1), 32'd300);
        chk("t5_count0", 32'(dl0 - bd0), 32'd300);
        chk("t5_left1", 32'(exp1.size() + q1.size()), 32'd0);
        chk("t5_left0", 32'(exp0.size() + q0.size()), 32'd0);

`ifdef I2CS_RD_STATS_EN
        // Long run past the 16-bit wrap
        guard = 0;
        while (npop1 < 70000 && guard < 75000) begin
            if (q1.size() < 8) begin
                for (int i = 0; i < 16; i++) push(8'(i));
            end
            tick();
            guard++;
        end
        en = 1'b0;
        chk("t6_pops", 32'(npop1), 32'd70000);
        chk("t6_popcnt", 32'(pc1), 32'd4464);
`endif
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
